// File: rtl/fib_pkg.sv
// Shared types and width helpers for the fast-Fibonacci engine.
package fib_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEF_NWIDTH = 32;
    localparam int DEF_WIDTH  = 32;

    // Sums of three 2W-bit products need two extra bits to stay exact.
    function automatic int sum_width(input int width);
        return 2 * width + 2;
    endfunction

endpackage

// File: rtl/fib_step.sv
// One fast-doubling step: conditional (a,b) advance plus (p,q) squaring, with overflow detect.
module fib_step
    import fib_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] q,
    input  logic             odd,
    input  logic             last,
    output logic [WIDTH-1:0] a_nxt,
    output logic [WIDTH-1:0] b_nxt,
    output logic [WIDTH-1:0] p_nxt,
    output logic [WIDTH-1:0] q_nxt,
    output logic             step_ovf
);

    localparam int PW = 2 * WIDTH;
    localparam int SW = sum_width(WIDTH);

    logic [PW-1:0] bq, aq, ap, bp, pp, qq, pq;
    logic [SW-1:0] a_sum, b_sum, p_sum, q_sum;
    logic          a_ovf, b_ovf, p_ovf, q_ovf;

    always_comb begin
        bq = PW'(b) * PW'(q);
        aq = PW'(a) * PW'(q);
        ap = PW'(a) * PW'(p);
        bp = PW'(b) * PW'(p);
        pp = PW'(p) * PW'(p);
        qq = PW'(q) * PW'(q);
        pq = PW'(p) * PW'(q);

        a_sum = SW'(bq) + SW'(aq) + SW'(ap);
        b_sum = SW'(bp) + SW'(aq);
        p_sum = SW'(pp) + SW'(qq);
        q_sum = SW'(qq) + (SW'(pq) << 1);

        a_ovf = |a_sum[SW-1:WIDTH];
        b_ovf = |b_sum[SW-1:WIDTH];
        p_ovf = |p_sum[SW-1:WIDTH];
        q_ovf = |q_sum[SW-1:WIDTH];

        a_nxt = odd ? a_sum[WIDTH-1:0] : a;
        b_nxt = odd ? b_sum[WIDTH-1:0] : b;
        p_nxt = p_sum[WIDTH-1:0];
        q_nxt = q_sum[WIDTH-1:0];

        // a, p and q are dead after the final step, so their overflow there is irrelevant.
        step_ovf = (odd & b_ovf) | (~last & ((odd & a_ovf) | p_ovf | q_ovf));
    end

endmodule

// File: rtl/fib_engine.sv
// Fast-Fibonacci engine: start/busy/done handshake around fib_step, one bit of n per cycle.
module fib_engine
    import fib_pkg::*;
#(
    parameter int NWIDTH   = DEF_NWIDTH,
    parameter int WIDTH    = DEF_WIDTH,
    parameter bit SATURATE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NWIDTH-1:0] n,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  fibn,
    output logic              ovf
);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, p_q, p_d, q_q, q_d;
    logic [NWIDTH-1:0] nr_q, nr_d;
    logic              ovf_acc_q, ovf_acc_d;
    logic              busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
    logic [WIDTH-1:0]  fibn_q, fibn_d;

    logic [WIDTH-1:0]  a_nxt, b_nxt, p_nxt, q_nxt;
    logic              step_ovf, last_step;

    assign last_step = (nr_q >> 1) == '0;

    fib_step #(.WIDTH(WIDTH)) u_step (
        .a        (a_q),
        .b        (b_q),
        .p        (p_q),
        .q        (q_q),
        .odd      (nr_q[0]),
        .last     (last_step),
        .a_nxt    (a_nxt),
        .b_nxt    (b_nxt),
        .p_nxt    (p_nxt),
        .q_nxt    (q_nxt),
        .step_ovf (step_ovf)
    );

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path through the case infers a latch.
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        p_d       = p_q;
        q_d       = q_q;
        nr_d      = nr_q;
        ovf_acc_d = ovf_acc_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        fibn_d    = fibn_q;
        ovf_d     = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d       = WIDTH'(1);
                    b_d       = '0;
                    p_d       = '0;
                    q_d       = WIDTH'(1);
                    nr_d      = n;
                    ovf_acc_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (nr_q == '0) begin
                    fibn_d  = (SATURATE && ovf_acc_q) ? '1 : b_q;
                    ovf_d   = ovf_acc_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    a_d       = a_nxt;
                    b_d       = b_nxt;
                    p_d       = p_nxt;
                    q_d       = q_nxt;
                    nr_d      = nr_q >> 1;
                    ovf_acc_d = ovf_acc_q | step_ovf;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values of its peers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fibn_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fibn_q  <= fibn_d;
            ovf_q   <= ovf_d;
        end
    end

    // NOTE: datapath registers are fully loaded on accept, so they carry no reset.
    always_ff @(posedge clk) begin
        a_q       <= a_d;
        b_q       <= b_d;
        p_q       <= p_d;
        q_q       <= q_d;
        nr_q      <= nr_d;
        ovf_acc_q <= ovf_acc_d;
    end

    assign busy = busy_q;
    assign done = done_q;
    assign fibn = fibn_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_fib_engine.sv
// Self-checking bench for fib_engine: three instances (32-bit, 8-bit wrap, 8-bit saturate).
module tb_fib_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] n;

    logic        busy32, done32, ovf32;
    logic [31:0] fibn32;
    logic        busy8, done8, ovf8;
    logic [7:0]  fibn8;
    logic        busy8s, done8s, ovf8s;
    logic [7:0]  fibn8s;

    int checks = 0;
    int errors = 0;
    string ctx = "init";

    always #5 clk = ~clk;

    fib_engine #(.NWIDTH(32), .WIDTH(32), .SATURATE(1'b0)) u_dut32 (
        .clk(clk), .rst(rst), .start(start), .n(n),
        .busy(busy32), .done(done32), .fibn(fibn32), .ovf(ovf32)
    );

    fib_engine #(.NWIDTH(32), .WIDTH(8), .SATURATE(1'b0)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .n(n),
        .busy(busy8), .done(done8), .fibn(fibn8), .ovf(ovf8)
    );

    fib_engine #(.NWIDTH(32), .WIDTH(8), .SATURATE(1'b1)) u_dut8s (
        .clk(clk), .rst(rst), .start(start), .n(n),
        .busy(busy8s), .done(done8s), .fibn(fibn8s), .ovf(ovf8s)
    );

    typedef struct {
        logic [31:0] n;
        int          lat;
        logic [31:0] f32;
        logic        o32;
        logic [7:0]  f8;
        logic        o8;
        logic [7:0]  f8s;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%s]: got %0d expected %0d", name, ctx, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int          cyc;
        logic [31:0] held;
        ctx = $sformatf("n=%0d", v.n);
        @(negedge clk);
        start = 1'b1;
        n     = v.n;
        held  = fibn32;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
        while (done32 !== 1'b1 && cyc < 100) begin
            check("busy during run", busy32, 1);
            check("fibn held during run", fibn32, held);
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency", cyc, v.lat);
        check("busy at done", busy32, 0);
        check("fibn32", fibn32, v.f32);
        check("ovf32", ovf32, v.o32);
        check("done8", done8, 1);
        check("fibn8", fibn8, v.f8);
        check("ovf8", ovf8, v.o8);
        check("done8s", done8s, 1);
        check("fibn8s", fibn8s, v.f8s);
        check("ovf8s", ovf8s, v.o8);
        @(posedge clk);
        #1;
        check("done single pulse", done32, 0);
        check("fibn held after done", fibn32, v.f32);
    endtask

    initial begin
        int cyc;
        int done_seen;

        vecs[0]  = '{32'd0,  1, 32'd0,          1'b0, 8'd0,   1'b0, 8'd0};
        vecs[1]  = '{32'd1,  2, 32'd1,          1'b0, 8'd1,   1'b0, 8'd1};
        vecs[2]  = '{32'd2,  3, 32'd1,          1'b0, 8'd1,   1'b0, 8'd1};
        vecs[3]  = '{32'd5,  4, 32'd5,          1'b0, 8'd5,   1'b0, 8'd5};
        vecs[4]  = '{32'd10, 5, 32'd55,         1'b0, 8'd55,  1'b0, 8'd55};
        vecs[5]  = '{32'd13, 5, 32'd233,        1'b0, 8'd233, 1'b0, 8'd233};
        vecs[6]  = '{32'd14, 5, 32'd377,        1'b0, 8'd121, 1'b1, 8'd255};
        vecs[7]  = '{32'd20, 6, 32'd6765,       1'b0, 8'd109, 1'b1, 8'd255};
        vecs[8]  = '{32'd47, 7, 32'd2971215073, 1'b0, 8'd225, 1'b1, 8'd255};
        vecs[9]  = '{32'd48, 7, 32'd512559680,  1'b1, 8'd64,  1'b1, 8'd255};
        vecs[10] = '{32'd7,  4, 32'd13,         1'b0, 8'd13,  1'b0, 8'd13};

        rst   = 1'b1;
        start = 1'b0;
        n     = '0;
        repeat (2) @(negedge clk);
        ctx = "reset";
        check("busy in reset", busy32, 0);
        check("done in reset", done32, 0);
        check("fibn in reset", fibn32, 0);
        check("ovf in reset", ovf32, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("busy after reset", busy32, 0);
        check("fibn8s after reset", fibn8s, 0);

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i]);
        end

        // n=0 then n=1 with start held through done
        ctx = "back-to-back";
        @(negedge clk);
        start = 1'b1;
        n     = 32'd0;
        @(posedge clk);
        #1;
        check("b2b busy after first accept", busy32, 1);
        check("b2b no early done", done32, 0);
        @(negedge clk);
        n = 32'd1;
        @(posedge clk);
        #1;
        check("b2b first done", done32, 1);
        check("b2b first fibn", fibn32, 0);
        check("b2b busy low at done", busy32, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b second accepted", busy32, 1);
        check("b2b done dropped", done32, 0);
        @(posedge clk);
        #1;
        check("b2b second mid-run done", done32, 0);
        check("b2b second mid-run fibn", fibn32, 0);
        @(posedge clk);
        #1;
        check("b2b second done", done32, 1);
        check("b2b second fibn", fibn32, 1);

        // start pulsed while busy must be ignored
        ctx = "ignored start";
        @(negedge clk);
        start = 1'b1;
        n     = 32'd20;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        cyc = 1;
        @(negedge clk);
        start = 1'b1;
        n     = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc++;
        while (done32 !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("ignored-start latency", cyc, 6);
        check("ignored-start fibn", fibn32, 6765);
        check("ignored-start ovf", ovf32, 0);
        check("ignored-start fibn8", fibn8, 109);
        @(posedge clk);
        #1;
        check("no queued run", busy32, 0);

        // reset two cycles into a run
        ctx = "mid-run reset";
        @(negedge clk);
        start = 1'b1;
        n     = 32'd20;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset busy", busy32, 0);
        check("reset done", done32, 0);
        check("reset fibn", fibn32, 0);
        check("reset ovf8", ovf8, 0);
        check("reset fibn8s", fibn8s, 0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done32 === 1'b1) done_seen++;
        end
        check("no done after abort", done_seen, 0);
        check("idle after abort", busy32, 0);
        run_vec(vecs[10]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fib_engine.md
# fib_engine

Parametrised fast-Fibonacci engine: computes F(n) by logarithmic doubling, consuming one bit of n per cycle. Operand and result widths are configurable. Overflow is detected and flagged, with optional saturation. Adds a reset, a start/busy/done handshake and a held result. Used as the arithmetic-kernel successor of the fixed 32-bit fast-Fibonacci unit, driven by a host FSM or testbench.

## Interface
- NWIDTH, 32, width of the index input n
- WIDTH, 32, width of the result and of all internal accumulators
- SATURATE, 0, if 1 then fibn is forced to all-ones when ovf is set; if 0 then fibn is F(n) mod 2^WIDTH
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; accepted only while busy=0
- n  in  NWIDTH  index, sampled on the accepting edge only
- busy  out  1  high from the accepting edge until the edge that raises done
- done  out  1  one-cycle pulse, result valid
- fibn  out  WIDTH  result, held until the next accepted start
- ovf  out  1  true F(n) ≥ 2^WIDTH; held with fibn

## Operation
- Registers: a, b, p, q (WIDTH each) and nr (NWIDTH).
- State machine has two states, IDLE and RUN.
- IDLE, start=1: load a=1, b=0, p=0, q=1, nr=n, clear ovf_acc, go to RUN, busy=1.
  - start while busy is ignored; it is neither queued nor able to abort the run.
- RUN, nr==0:
  - fibn ← b, or all-ones if SATURATE and ovf_acc
  - ovf ← ovf_acc, done=1 for one cycle, busy=0, go to IDLE
- RUN, nr≠0:
  - if nr[0]: a ← b·q + a·q + a·p; b ← b·p + a·q
  - always: p ← p² + q²; q ← q² + 2·p·q; nr ← nr >> 1
  - All right-hand sides use pre-edge values.
- Arithmetic width rules:
  - Products are formed at 2·WIDTH bits; sums at 2·WIDTH+2 bits.
  - Stored values are the low WIDTH bits.
- ovf_acc is sticky and is set when any of the following holds:
  - the b update exceeds 2^WIDTH−1
  - the a, p or q update exceeds 2^WIDTH−1 and (nr>>1)≠0
  - Overflow of a, p or q on the final update is discarded, because those values are never used. This rule is mandatory: without it, F(13) at WIDTH=8 would be falsely flagged.
- n=0 yields fibn=0, ovf=0.

## Timing
- Reset values: state IDLE, busy=0, done=0, fibn=0, ovf=0; internal registers are don't-care.
- Reset asserted mid-RUN aborts the run:
  - no done pulse is produced
  - fibn and ovf return to 0
- Latency: let k be the number of significant bits of n (k=0 for n=0).
  - Accept on edge E; updates occur on edges E+1..E+k.
  - done is high after edge E+k+1, together with the new fibn and ovf.
  - Examples: n=10 gives done 5 cycles after acceptance; n=0 gives 1 cycle.
- Back-to-back runs: start may be high in the same cycle done is high. That start is not accepted, because the FSM is still in RUN. It is accepted on the following edge (in IDLE).
- fibn and ovf change only on the done edge or on reset. They remain stable while a new run is in progress.

## Structure
- Package fib_pkg:
  - state enum (IDLE, RUN)
  - default widths
  - helper constant for 2·WIDTH+2
- Sub-module fib_step (combinational, parametrised by WIDTH):
  - inputs: a, b, p, q, odd, last
  - outputs: next a, b, p, q and step_ovf
  - step_ovf applies the last-step masking rule above.
- fib_engine contains the FSM, registers, handshake and saturation muxing only.

## Test plan
- Reset, then n=10, WIDTH=32: busy high for 5 cycles; done pulses once; fibn=55, ovf=0.
- n=0, then immediately n=1 (start held through done): first run gives fibn=0 after 1 cycle; second gives fibn=1 after 2 cycles with no lost request.
- WIDTH=32, n=47 → fibn=2971215073, ovf=0; n=48 → ovf=1, fibn=512559680 (SATURATE=0).
- WIDTH=8: n=13 → fibn=233, ovf=0 (final a=377 and p/q overflow masked); n=14 → ovf=1, fibn=121 (SATURATE=0) or 255 (SATURATE=1).
- Pulse start with n=5 while busy during an n=20 run: ignored; fibn=6765 after 6 cycles.
- Assert rst two cycles into an n=20 run: busy, done, fibn and ovf drop to 0 immediately; no done pulse; a fresh n=7 run then gives 13.
